// File: rtl/chip8_fb_arbiter.sv
// chip8_fb_arbiter: shares one framebuffer RAM between VGA pixel fetch and a CLEAR / sprite-row XOR draw engine
//   i_clk50, i_reset                : 50 MHz clock, asynchronous active-high reset
//   i_vga_addr -> o_fb_pixel_data   : VGA fetch on even (phase 0) slots, registered pixel back
//   i_cmd_valid/o_cmd_ready, i_cmd_*: command handshake; op 0 = draw sprite row at (x,y), op 1 = clear
//   o_done, o_collision             : one-cycle completion pulse, sticky draw collision result
//   o_ram_addr/wdata/we, i_ram_rdata: single-port RAM with 1-cycle registered read
module chip8_fb_arbiter #(
  parameter int FB_W = 64,
  parameter int FB_H = 32
) (
  input  logic                         i_clk50,
  input  logic                         i_reset,
  input  logic [$clog2(FB_W*FB_H)-1:0] i_vga_addr,
  output logic                         o_fb_pixel_data,
  input  logic                         i_cmd_valid,
  output logic                         o_cmd_ready,
  input  logic                         i_cmd_op,
  input  logic [$clog2(FB_W)-1:0]      i_cmd_x,
  input  logic [$clog2(FB_H)-1:0]      i_cmd_y,
  input  logic [7:0]                   i_cmd_row,
  output logic                         o_done,
  output logic                         o_collision,
  output logic [$clog2(FB_W*FB_H)-1:0] o_ram_addr,
  output logic                         o_ram_wdata,
  output logic                         o_ram_we,
  input  logic                         i_ram_rdata
);
  localparam int XW = $clog2(FB_W);
  localparam int YW = $clog2(FB_H);
  localparam int AW = XW + YW;
  typedef enum logic [2:0] {S_IDLE, S_DRAW_RD, S_DRAW_WR, S_CLEAR, S_DONE} state_t;
  state_t          r_state, w_next;
  logic            r_phase, r_pix, r_old, r_coll;
  logic [XW-1:0]   r_x;
  logic [YW-1:0]   r_y;
  logic [7:0]      r_row;
  logic [2:0]      r_i;
  logic [AW-1:0]   r_cnt;
  logic            w_accept, w_slot_we, w_slot_wdata;
  logic [AW-1:0]   w_slot_addr, w_pix_addr;
  logic [2:0]      w_off;
  assign w_accept = (r_state == S_IDLE) && i_cmd_valid;
  // pixel offset from the start column is 7-i, which is ~i for a 3-bit index
  assign w_off = ~r_i;
  // column add is XW bits wide so drawing past the right edge wraps to column 0
  assign w_pix_addr = {r_y, r_x + XW'(w_off)};
  assign o_cmd_ready     = (r_state == S_IDLE);
  assign o_done          = (r_state == S_DONE);
  assign o_collision     = r_coll;
  assign o_fb_pixel_data = r_pix;
  // slot signals are only ever non-zero in phase 1, so phase 0 belongs to VGA
  assign o_ram_addr  = r_phase ? w_slot_addr : i_vga_addr;
  assign o_ram_we    = w_slot_we;
  assign o_ram_wdata = w_slot_wdata;
  always_ff @(posedge i_clk50 or posedge i_reset)
    if (i_reset) r_state <= S_IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next       = r_state;
    w_slot_addr  = '0;
    w_slot_we    = 1'b0;
    w_slot_wdata = 1'b0;
    case (r_state)
      S_IDLE:    w_next = i_cmd_valid ? (i_cmd_op ? S_CLEAR : S_DRAW_RD) : S_IDLE;
      S_DRAW_RD: if (r_phase) begin
        w_slot_addr = w_pix_addr;
        w_next      = S_DRAW_WR;
      end
      S_DRAW_WR: if (r_phase) begin
        // a clear sprite bit still burns the slot to keep the 4-cycle pixel cadence
        w_slot_addr  = w_pix_addr;
        w_slot_we    = r_row[r_i];
        w_slot_wdata = r_row[r_i] & ~r_old;
        w_next       = (r_i == 3'd0) ? S_DONE : S_DRAW_RD;
      end
      S_CLEAR:   if (r_phase) begin
        w_slot_addr = r_cnt;
        w_slot_we   = 1'b1;
        w_next      = (&r_cnt) ? S_DONE : S_CLEAR;
      end
      S_DONE:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge i_clk50 or posedge i_reset)
    if (i_reset) begin
      r_phase <= 1'b0;
      r_pix   <= 1'b0;
      r_old   <= 1'b0;
      r_coll  <= 1'b0;
      r_x     <= '0;
      r_y     <= '0;
      r_row   <= '0;
      r_i     <= 3'd7;
      r_cnt   <= '0;
    end else begin
      r_phase <= ~r_phase;
      // read data seen in phase 1 answers the VGA address of the preceding phase 0
      if (r_phase) r_pix <= i_ram_rdata;
      if (w_accept) begin
        r_x    <= i_cmd_x;
        r_y    <= i_cmd_y;
        r_row  <= i_cmd_row;
        r_i    <= 3'd7;
        r_cnt  <= '0;
        r_coll <= 1'b0;
      end
      // the engine read issued in phase 1 returns during the following phase 0
      if (r_state == S_DRAW_WR && !r_phase) r_old <= i_ram_rdata;
      if (r_state == S_DRAW_WR && r_phase) begin
        r_i <= r_i - 3'd1;
        if (r_row[r_i] && r_old) r_coll <= 1'b1;
      end
      if (r_state == S_CLEAR && r_phase) r_cnt <= r_cnt + AW'(1);
    end
endmodule

// File: tb/tb_chip8_fb_arbiter.sv
// tb_chip8_fb_arbiter: scoreboard bench for the framebuffer arbiter and draw engine
module tb_chip8_fb_arbiter;
  logic        clk = 1'b0, rst = 1'b0;
  logic [10:0] vga_addr = '0;
  logic        pix, cmd_ready, done, coll, ram_wdata, ram_we;
  logic        cmd_valid = 1'b0, cmd_op = 1'b0, ram_rdata = 1'b0;
  logic [5:0]  cmd_x = '0;
  logic [4:0]  cmd_y = '0;
  logic [7:0]  cmd_row = '0;
  logic [10:0] ram_addr;
  logic        mem [2048];
  logic        ref_fb [2048];
  bit          ram_init = 1'b0;
  int          cyc = 0, checks = 0, fails = 0;
  typedef struct { int c; int a; logic d; } wr_t;
  typedef struct { int c; logic v; } vg_t;
  wr_t wq [$];
  vg_t vq [$];
  int  dq [$];
  wr_t w_e;
  vg_t v_e;
  int  d_e;

  chip8_fb_arbiter dut (
    .i_clk50(clk), .i_reset(rst), .i_vga_addr(vga_addr), .o_fb_pixel_data(pix),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_op(cmd_op),
    .i_cmd_x(cmd_x), .i_cmd_y(cmd_y), .i_cmd_row(cmd_row),
    .o_done(done), .o_collision(coll),
    .o_ram_addr(ram_addr), .o_ram_wdata(ram_wdata), .o_ram_we(ram_we), .i_ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst)
    if (rst) cyc <= 0;
    else cyc <= cyc + 1;

  // single-port RAM, read-before-write, 1-cycle registered read, random power-up contents
  always @(posedge clk) begin
    if (!ram_init) begin
      for (int a = 0; a < 2048; a++) mem[a] = 1'($urandom_range(0, 1));
      ram_init = 1'b1;
    end
    ram_rdata <= mem[ram_addr];
    if (ram_we) mem[ram_addr] = ram_wdata;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int fb_diff();
    int n = 0;
    for (int a = 0; a < 2048; a++) if (mem[a] !== ref_fb[a]) n++;
    return n;
  endfunction

  // scoreboard consumers: RAM writes, done pulses and VGA pixels
  always @(negedge clk) begin
    if (ram_we) begin
      if (wq.size() > 0) w_e = wq.pop_front();
      else begin w_e.c = -1; w_e.a = 0; w_e.d = 1'b0; end
      chk("we_in_phase1", 32'(cyc & 1), 32'd1);
      chk("ram_write", {cyc[15:0], 4'd0, ram_addr, ram_wdata}, {w_e.c[15:0], 4'd0, w_e.a[10:0], w_e.d});
    end
    if (done) begin
      if (dq.size() > 0) d_e = dq.pop_front();
      else d_e = -1;
      chk("done_cycle", cyc, d_e);
      chk("done_ready_low", 32'(cmd_ready), 32'd0);
    end
    while (vq.size() > 0 && vq[0].c == cyc) begin
      v_e = vq.pop_front();
      chk("vga_pixel", 32'(pix), 32'(v_e.v));
    end
  end

  // drive one command at a negedge and push its expected writes / done cycle
  task automatic issue(input logic op, input int x, input int y, input logic [7:0] row,
                       input int lim, output logic ecoll, output int so);
    int n = 0, a;
    wr_t w;
    ecoll = 1'b0;
    while (cmd_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    chk("cmd_ready", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_op = op; cmd_x = 6'(x); cmd_y = 5'(y); cmd_row = row;
    so = cyc + 1 + (cyc % 2);
    if (op) begin
      for (int k = 0; k < lim; k++) begin
        w.c = so + 2 * k; w.a = k; w.d = 1'b0;
        wq.push_back(w);
        ref_fb[k] = 1'b0;
      end
      if (lim == 2048) dq.push_back(so + 4095);
    end else begin
      for (int k = 0; k < 8; k++) if (row[7-k]) begin
        a = y * 64 + (x + k) % 64;
        if (ref_fb[a] === 1'b1) ecoll = 1'b1;
        ref_fb[a] = ~ref_fb[a];
        w.c = so + 2 + 4 * k; w.a = a; w.d = ref_fb[a];
        wq.push_back(w);
      end
      dq.push_back(so + 31);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (dq.size() != 0 && n < budget) begin @(negedge clk); n++; end
    chk({tag, "_done_seen"}, dq.size(), 32'd0);
    @(negedge clk);
    chk({tag, "_ready_after"}, 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    logic ec;
    int s, k;
    #1 rst = 1'b1;
    vga_addr = 11'd123;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_coll", 32'(coll), 32'd0);
    chk("rst_pix", 32'(pix), 32'd0);
    chk("rst_we", 32'(ram_we), 32'd0);
    chk("rst_wdata", 32'(ram_wdata), 32'd0);
    chk("rst_addr", 32'(ram_addr), 32'd123);
    rst = 1'b0;
    // full clear over random contents
    issue(1'b1, 0, 0, 8'h00, 2048, ec, s);
    wait_done("clear1", 4200);
    chk("clear1_coll", 32'(coll), 32'd0);
    chk("clear1_fb", fb_diff(), 32'd0);
    // draw 0xA5 at (10,5) then repeat it to erase and collide
    issue(1'b0, 10, 5, 8'hA5, 0, ec, s);
    wait_done("draw1", 100);
    chk("draw1_coll", 32'(coll), 32'd0);
    chk("draw1_set", 32'({mem[330], mem[332], mem[335], mem[337]}), 32'hF);
    chk("draw1_clr", 32'({mem[331], mem[333], mem[334], mem[336]}), 32'h0);
    chk("draw1_fb", fb_diff(), 32'd0);
    issue(1'b0, 10, 5, 8'hA5, 0, ec, s);
    wait_done("draw2", 100);
    chk("draw2_coll", 32'(coll), 32'd1);
    chk("draw2_px", 32'({mem[330], mem[332], mem[335], mem[337]}), 32'h0);
    chk("draw2_fb", fb_diff(), 32'd0);
    // x wrap at the right edge on the last row
    issue(1'b1, 0, 0, 8'h00, 2048, ec, s);
    wait_done("clear2", 4200);
    chk("clear2_coll", 32'(coll), 32'd0);
    issue(1'b0, 60, 31, 8'hFF, 0, ec, s);
    wait_done("wrap", 100);
    chk("wrap_coll", 32'(coll), 32'd0);
    chk("wrap_hi", 32'({mem[2044], mem[2045], mem[2046], mem[2047]}), 32'hF);
    chk("wrap_lo", 32'({mem[1984], mem[1985], mem[1986], mem[1987]}), 32'hF);
    chk("wrap_fb", fb_diff(), 32'd0);
    // VGA sweep across the pixels being drawn, with a stray CLEAR request that must be ignored
    issue(1'b0, 62, 31, 8'hB6, 0, ec, s);
    for (int c = 0; c < 36; c++) begin
      if (cyc % 2 == 0) begin
        k = (cyc <= s) ? 0 : (cyc - s - 1) / 4;
        if (k > 7) k = 7;
        vga_addr = 11'(31 * 64 + (62 + k) % 64);
        v_e.c = cyc + 2; v_e.v = mem[vga_addr]; vq.push_back(v_e);
        v_e.c = cyc + 3; vq.push_back(v_e);
      end
      cmd_valid = (c < 20);
      cmd_op = 1'b1;
      @(negedge clk);
    end
    chk("sweep_done", dq.size(), 32'd0);
    chk("sweep_coll", 32'(coll), 32'(ec));
    chk("sweep_ready", 32'(cmd_ready), 32'd1);
    chk("sweep_fb", fb_diff(), 32'd0);
    // reset in the middle of a clear: only the first five writes may land
    issue(1'b1, 0, 0, 8'h00, 5, ec, s);
    while (cyc < s + 9) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    vga_addr = 11'd555;
    repeat (3) @(negedge clk);
    chk("rst_mid_wq", wq.size(), 32'd0);
    rst = 1'b0;
    #1;
    chk("rel_ready", 32'(cmd_ready), 32'd1);
    chk("rel_phase0", 32'(ram_addr), 32'd555);
    @(negedge clk);
    chk("rel_phase1", 32'(ram_addr), 32'd0);
    chk("rst_mid_fb", fb_diff(), 32'd0);
    issue(1'b0, 3, 2, 8'h81, 0, ec, s);
    wait_done("post_rst", 100);
    chk("post_rst_coll", 32'(coll), 32'd0);
    chk("post_rst_px", 32'({mem[131], mem[138]}), 32'h3);
    chk("post_rst_fb", fb_diff(), 32'd0);
    repeat (4) @(negedge clk);
    chk("end_wq", wq.size(), 32'd0);
    chk("end_dq", dq.size(), 32'd0);
    chk("end_vq", vq.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/chip8_fb_arbiter.md
# chip8_fb_arbiter

Arbiter and draw sequencer for the Chip-8 64x32 1-bit framebuffer RAM. It time-slices one single-port RAM between the VGA emulator's pixel fetch path and a command-driven draw engine. The engine executes CLEAR and sprite-row XOR draws with collision detection. It sits between the CPU core, the framebuffer RAM and the VGA emulator, and replaces any direct CPU writes to the framebuffer.

## Interface
Parameters:
- FB_W, 64: framebuffer width in pixels; x field is 6 bits, wraps mod 64.
- FB_H, 32: framebuffer height in pixels; y field is 5 bits.

Ports:
- clk50  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-high reset.
- vga_addr  in  11  pixel address requested by VGA emulator, y*64+x.
- fb_pixel_data  out  1  registered pixel value returned to VGA emulator.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  engine idle, command accepted when cmd_valid & cmd_ready.
- cmd_op  in  1  0 = DRAW row, 1 = CLEAR.
- cmd_x  in  6  DRAW start column.
- cmd_y  in  5  DRAW row; the caller applies any y wrap.
- cmd_row  in  8  sprite byte; bit 7 is the leftmost pixel.
- done  out  1  one-cycle pulse when a command completes.
- collision  out  1  DRAW result; valid from done, held until next accept.
- ram_addr  out  11  RAM address.
- ram_wdata  out  1  RAM write data.
- ram_we  out  1  RAM write enable.
- ram_rdata  in  1  RAM read data; 1-cycle registered latency.

## Operation
- Slot scheduler: a `phase` bit toggles every clk50 cycle. Reset sets it to 0.
  - phase 0 is the VGA slot: ram_addr = vga_addr, ram_we = 0.
  - phase 1 is the engine slot: ram_addr/ram_we/ram_wdata are driven by the FSM. When the FSM has no access, ram_we = 0 and ram_addr = 0.
- VGA path: on the clock edge ending a phase-1 cycle, fb_pixel_data <= ram_rdata. This is the data for the address presented in the preceding phase 0.
- FSM states: IDLE, DRAW_RD, DRAW_WR, CLEAR, DONE.
- IDLE: cmd_ready = 1. On accept, latch x/y/row/op, set bit index i = 7, and clear collision.
  - op 0 goes to DRAW_RD.
  - op 1 goes to CLEAR with counter = 0.
- DRAW_RD: the FSM waits for a phase-1 slot, then issues a read of addr = {y, (x+7-i) mod 64} with we = 0. It then goes to DRAW_WR.
- DRAW_WR: the FSM waits for the next phase-1 slot. ram_rdata was captured on the intervening phase 0. At the slot:
  - If row[i] = 1: write ~old to the same addr, and set collision if old = 1.
  - If row[i] = 0: no write, but the slot is still consumed.
  - If i = 0, go to DONE; otherwise decrement i and go to DRAW_RD.
- x wrap uses a 6-bit add. Pixel x = 62 with i-offset 3 maps to column 1.
- CLEAR: on each phase-1 slot, write 0 to addr = counter and increment it. After addr 2047 is written, go to DONE.
- DONE: done = 1 for exactly one cycle, then return to IDLE. collision holds its value.
- Reset mid-command: the FSM returns to IDLE immediately. No further RAM writes occur and done is not pulsed. Partially drawn pixels remain in RAM.
- cmd_valid outside IDLE is ignored; the command is not queued.

## Timing
- Reset values:
  - phase = 0; state IDLE.
  - cmd_ready = 1; done = 0; collision = 0.
  - fb_pixel_data = 0.
  - ram_we = 0; ram_addr = vga_addr (phase 0 mux); ram_wdata = 0.
- VGA latency: vga_addr presented in phase-0 cycle t gives fb_pixel_data valid at cycles t+2 and t+3. The VGA emulator changes the address at most every 2 cycles.
- Same-pair hazard: a VGA read in phase 0 of a pair sees the pre-write value of an engine write in phase 1 of the same pair.
- Let S be the first phase-1 cycle strictly after the accept edge.
- DRAW: reads occur at S, S+4, …, S+28. Writes (when the bit is 1) occur at S+2, S+6, …, S+30. done asserts at S+31, and cmd_ready is high from S+32.
- CLEAR: writes occur at S+2k for k = 0..2047. done asserts at S+4095, and cmd_ready is high from S+4096.
- ram_we is never 1 in a phase-0 cycle.

## Test plan
- Reset, then CLEAR: every address written 0 exactly once, in order 0..2047. done pulses once at S+4095, collision = 0, ram_we is never high on phase 0.
- After CLEAR, DRAW x=10 y=5 row=0xA5: pixels at addr 330, 332, 335, 337 become 1 and the others stay 0. collision = 0 and done arrives at S+31.
- Repeat the same DRAW: those 4 pixels return to 0 and collision = 1.
- DRAW x=60 y=31 row=0xFF on a cleared screen: addrs 2044–2047 and 1984–1987 are set, confirming x wrap; collision = 0.
- Continuous VGA sweep of vga_addr during a DRAW: fb_pixel_data matches a RAM model with 2-cycle latency. A read of a pixel written in the same pair returns the old value.
- Assert reset at S+10 of a CLEAR:
  - no writes occur after reset;
  - done never pulses;
  - cmd_ready = 1 and phase = 0 after release;
  - a new DRAW is then accepted and completes normally.
